input_debouncer: RTL



---
 rtl/input_debouncer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/input_debouncer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// input_debouncer
//
// Conditions a raw, bouncy level input (push-button, switch) into a clean
// registered level plus single-cycle edge pulses. A new level is accepted
// only after the sampled input has held it for STABLE_CYCLES+1 consecutive
// samples; any reversal while qualifying rejects the change.
//
// Build option:
//   INPUT_DEBOUNCER_SYNC_EN  defined   : Din passes through a two-flop
//                                        synchronizer (adds 2 cycles latency)
//                            undefined : Din is used directly (already
//                                        synchronous to Clk)
//
// Parameters:
//   STABLE_CYCLES  extra identical samples needed to accept a level (1..65535)
//   CNT_W          qualification counter width (derived, do not override)
//
// Ports:
//   Clk   in   system clock, rising edge
//   Rst   in   asynchronous active-high reset
//   Din   in   raw input level
//   Q     out  debounced level (registered)
//   Rise  out  one-cycle pulse on an accepted 0->1 change (registered)
//   Fall  out  one-cycle pulse on an accepted 1->0 change (registered)
// -----------------------------------------------------------------------------
module input_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Din,
  output logic Q,
  output logic Rise,
  output logic Fall
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             q_next, rise_next, fall_next;
  logic             s;

  // ---------------------------------------------------------------------------
  // Input sampling
  // ---------------------------------------------------------------------------
`ifdef INPUT_DEBOUNCER_SYNC_EN
  logic sync_meta, sync_out;

  // sync_meta may go metastable; only sync_out, one full cycle later, is used.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples its inputs as they were before the edge.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      sync_meta <= Din;
      sync_out  <= sync_meta;
    end
  end

  assign s = sync_out;
`else
  assign s = Din;
`endif

  // ---------------------------------------------------------------------------
  // State, counter and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE_LOW;
      cnt   <= '0;
      Q     <= 1'b0;
      Rise  <= 1'b0;
      Fall  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      Q     <= q_next;
      Rise  <= rise_next;
      Fall  <= fall_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_next = state;
    cnt_next   = cnt;
    q_next     = Q;
    rise_next  = 1'b0;
    fall_next  = 1'b0;

    unique case (state)
      IDLE_LOW: begin
        if (s) begin
          state_next = WAIT_HIGH;
          cnt_next   = '0;
        end
      end

      WAIT_HIGH: begin
        if (!s) begin
          // Glitch: drop back without any pulse.
          state_next = IDLE_LOW;
          cnt_next   = '0;
        end else if (cnt == CNT_MAX) begin
          state_next = IDLE_HIGH;
          q_next     = 1'b1;
          rise_next  = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      IDLE_HIGH: begin
        if (!s) begin
          state_next = WAIT_LOW;
          cnt_next   = '0;
        end
      end

      WAIT_LOW: begin
        if (s) begin
          state_next = IDLE_HIGH;
          cnt_next   = '0;
        end else if (cnt == CNT_MAX) begin
          state_next = IDLE_LOW;
          q_next     = 1'b0;
          fall_next  = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      default: begin
        state_next = IDLE_LOW;
        cnt_next   = '0;
        q_next     = 1'b0;
      end
    endcase
  end

endmodule
